// File: rtl/pool_arb_pkg.sv
// Shared opcode/state types and opcode decode helpers for the dictionary-pool arbiter.
// Purely declarative: no latency, no flow control.
package pool_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_R1   = 3'd1,
        OP_R2   = 3'd2,
        OP_R4   = 3'd3,
        OP_FIND = 3'd4,
        OP_W1   = 3'd5,
        OP_W2   = 3'd6,
        OP_W4   = 3'd7
    } pool_ops_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // The low two opcode bits encode the transfer size for both reads and writes.
    function automatic logic [2:0] nbytes(input logic [2:0] op);
        case (op[1:0])
            2'd2:    return 3'd2;
            2'd3:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic is_wr(input logic [2:0] op);
        return op[2] && (op != OP_FIND);
    endfunction

    // NOP and FIND both have zero low bits and never touch the SPRAM.
    function automatic logic is_mem(input logic [2:0] op);
        return op[1:0] != 2'd0;
    endfunction

endpackage

// File: rtl/pool_arb_if.sv
// Requester-side bundle of the pool arbiter: request levels, per-port commands, grant/ack and read result.
// Requests are level-held until ack; the arbiter is the only source of gnt/ack/rdata/busy.
interface pool_arb_if #(
    parameter int NREQ = 3,
    parameter int ASZ  = 17
);
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][2:0]      op;
    logic [NREQ-1:0][ASZ-1:0]  addr;
    logic [NREQ-1:0][31:0]     wdata;
    logic [NREQ-1:0]           gnt;
    logic [NREQ-1:0]           ack;
    logic [31:0]               rdata;
    logic                      busy;

    modport master (
        output req, op, addr, wdata,
        input  gnt, ack, rdata, busy
    );

    modport slave (
        input  req, op, addr, wdata,
        output gnt, ack, rdata, busy
    );
endinterface

// File: rtl/pool_arb_rr_pick.sv
// Combinational round-robin picker: first active request after ptr, wrapping, with a per-port mask.
// Zero latency; no flow control.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] win,
    output logic            valid
);
    logic [NREQ-1:0] w_act;

    assign w_act = req & ~mask;

    // Two passes: indices above ptr first, then wrap round to 0..ptr.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && w_act[j] && (j > int'(ptr))) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && w_act[j] && (j <= int'(ptr))) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_arb.sv
// Round-robin arbiter sharing the 8-bit dictionary SPRAM; each grant becomes 1/2/4 byte cycles.
// Latency W:n+1, R:n+2, NOP/FIND:1 cycles from the sampling IDLE cycle; requesters hold req until ack.
module pool_arb
    import pool_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ASZ  = 17
) (
    input  logic            clk,
    input  logic            rst,
    pool_arb_if.slave       bus,
    output logic            mem_we,
    output logic [ASZ-1:0]  mem_a,
    output logic [7:0]      mem_vi,
    input  logic [7:0]      mem_vo
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_mask;
    logic [PW-1:0]   r_ptr;
    logic [2:0]      r_op;
    logic [ASZ-1:0]  r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [2:0]      r_cnt;

    logic [NREQ-1:0] w_win;
    logic            w_vld;
    logic [2:0]      w_op;
    logic [ASZ-1:0]  w_addr;
    logic [31:0]     w_wdata;
    logic [PW-1:0]   w_gidx;
    logic            w_wr;
    logic            w_last;
    logic            w_cap;
    logic [1:0]      w_bi;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .mask  (r_mask),
        .win   (w_win),
        .valid (w_vld)
    );

    always_comb begin
        w_op    = '0;
        w_addr  = '0;
        w_wdata = '0;
        w_gidx  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win[j]) begin
                w_op    = bus.op[j];
                w_addr  = bus.addr[j];
                w_wdata = bus.wdata[j];
            end
            if (r_gnt[j]) begin
                w_gidx = PW'(j);
            end
        end
    end

    assign w_wr   = is_wr(r_op);
    assign w_last = (r_cnt == nbytes(r_op) - 3'd1);
    // SPRAM read data lags its address by one cycle, so byte cnt-1 lands now.
    assign w_cap  = ((r_state == ST_XFER) && !w_wr && (r_cnt != 3'd0)) || (r_state == ST_DRAIN);
    assign w_bi   = 2'(r_cnt - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        mem_a       = '0;
        mem_vi      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_vld) begin
                    w_state_nxt = is_mem(w_op) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                mem_a = r_addr + {{(ASZ-3){1'b0}}, r_cnt};
                if (w_wr) begin
                    mem_we = 1'b1;
                    mem_vi = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                end
                if (w_last) begin
                    w_state_nxt = w_wr ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_mask  <= '0;
            r_ptr   <= PW'(NREQ - 1);
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mask <= '0;
                    if (w_vld) begin
                        r_gnt   <= w_win;
                        r_op    <= w_op;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        // Only reads clear the result, so writes leave the last read visible.
                        if (is_mem(w_op) && !is_wr(w_op)) begin
                            r_rdata <= '0;
                        end
                    end
                end
                ST_XFER: r_cnt <= r_cnt + 3'd1;
                ST_DONE: begin
                    r_ptr  <= w_gidx;
                    r_mask <= r_gnt;
                    r_gnt  <= '0;
                end
                default: ;
            endcase
            if (w_cap) begin
                r_rdata[{w_bi, 3'b000} +: 8] <= mem_vo;
            end
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.ack   = (r_state == ST_DONE) ? r_gnt : '0;
    assign bus.rdata = r_rdata;
    assign bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pool_arb.sv
// Directed bench for pool_arb with a behavioural registered-read SPRAM.
// Table of single-port transactions plus hand sequences for rotation and mid-transfer reset.
module tb_pool_arb;
    import pool_pkg::*;

    localparam int NREQ = 3;
    localparam int ASZ  = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_we;
    logic [ASZ-1:0] mem_a;
    logic [7:0]     mem_vi;
    logic [7:0]     mem_vo;
    logic [7:0]     spram [0:(1<<ASZ)-1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pool_arb_if #(.NREQ(NREQ), .ASZ(ASZ)) bus ();

    pool_arb #(.NREQ(NREQ), .ASZ(ASZ)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_vi (mem_vi),
        .mem_vo (mem_vo)
    );

    always @(posedge clk) begin
        if (mem_we) spram[mem_a] <= mem_vi;
        mem_vo <= spram[mem_a];
    end

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          chk_rd;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the arbiter idle and unmasked; returns two idle cycles after ack.
    task automatic run_txn(input vec_t v, input string tag);
        int              cyc;
        int              we_cnt;
        bit              got;
        logic [NREQ-1:0] gnt1;
        logic [NREQ-1:0] ackv;
        logic [31:0]     oh;
        oh = 32'd1 << v.port;
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        bus.op[v.port]    = v.op;
        bus.addr[v.port]  = v.addr;
        bus.wdata[v.port] = v.wdata;
        bus.req[v.port]   = 1'b1;
        cyc = 0; we_cnt = 0; got = 1'b0; gnt1 = '0; ackv = '0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) gnt1 = bus.gnt;
            if (mem_we) we_cnt++;
            if (bus.ack != '0) begin
                got  = 1'b1;
                ackv = bus.ack;
            end
        end
        bus.req[v.port] = 1'b0;
        check({tag, " latency"}, cyc, v.exp_lat);
        check({tag, " ack"}, {29'd0, ackv}, oh);
        check({tag, " gnt"}, {29'd0, gnt1}, oh);
        check({tag, " we_cycles"}, we_cnt, v.exp_we);
        if (v.chk_rd) check({tag, " rdata"}, bus.rdata, v.exp_rd);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a01, a02, a1, a2, nacks;
        logic [31:0] exp_b;
        bit          ack_seen;

        rst = 1'b1;
        bus.req = '0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < (1 << ASZ); i++) spram[i] = 8'h00;

        //            port op       addr       wdata         exp_rd        chk lat we
        vt[0]  = '{1, OP_W4,   17'h00100, 32'hDEADBEEF, 32'h0,        1'b0, 5, 4};
        vt[1]  = '{0, OP_R2,   17'h00102, 32'h0,        32'h0000DEAD, 1'b1, 4, 0};
        vt[2]  = '{0, OP_R4,   17'h00100, 32'h0,        32'hDEADBEEF, 1'b1, 6, 0};
        vt[3]  = '{2, OP_W2,   17'h1FFFF, 32'h00001234, 32'h0,        1'b0, 3, 2};
        vt[4]  = '{1, OP_R2,   17'h1FFFF, 32'h0,        32'h00001234, 1'b1, 4, 0};
        vt[5]  = '{2, OP_FIND, 17'h00040, 32'h0,        32'h0,        1'b0, 1, 0};
        vt[6]  = '{2, OP_NOP,  17'h00040, 32'h0,        32'h0,        1'b0, 1, 0};
        vt[7]  = '{0, OP_R1,   17'h00103, 32'h0,        32'h000000DE, 1'b1, 3, 0};
        vt[8]  = '{1, OP_W1,   17'h00200, 32'hFFFFFFA5, 32'h0,        1'b0, 2, 1};
        vt[9]  = '{2, OP_R1,   17'h00200, 32'h0,        32'h000000A5, 1'b1, 3, 0};
        vt[10] = '{0, OP_R4,   17'h1FFFE, 32'h0,        32'h00123400, 1'b1, 6, 0};

        repeat (3) @(negedge clk);
        check("rst gnt",    {29'd0, bus.gnt}, 32'd0);
        check("rst ack",    {29'd0, bus.ack}, 32'd0);
        check("rst busy",   {31'd0, bus.busy}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_a",  {15'd0, mem_a}, 32'd0);
        check("rst mem_vi", {24'd0, mem_vi}, 32'd0);
        check("rst rdata",  bus.rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_txn(vt[i], $sformatf("v%0d", i));

        check("mem 0x100",   {24'd0, spram[17'h00100]}, 32'hEF);
        check("mem 0x101",   {24'd0, spram[17'h00101]}, 32'hBE);
        check("mem 0x102",   {24'd0, spram[17'h00102]}, 32'hAD);
        check("mem 0x103",   {24'd0, spram[17'h00103]}, 32'hDE);
        check("mem 0x1FFFF", {24'd0, spram[17'h1FFFF]}, 32'h34);
        check("mem 0x00000", {24'd0, spram[17'h00000]}, 32'h12);
        check("mem 0x201",   {24'd0, spram[17'h00201]}, 32'h00);

        // Simultaneous R1 on all ports from reset; port 0 re-requests right after its ack.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.op    = {OP_R1, OP_R1, OP_R1};
        bus.addr  = {17'h00102, 17'h00101, 17'h00100};
        bus.req   = 3'b111;
        a01 = -1; a02 = -1; a1 = -1; a2 = -1; nacks = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (a01 > 0 && c == a01 + 1) begin
                bus.addr[0] = 17'h00103;
                bus.req[0]  = 1'b1;
            end
            for (int p = 0; p < NREQ; p++) begin
                if (bus.ack[p]) begin
                    nacks++;
                    bus.req[p] = 1'b0;
                    if (p == 0 && a01 < 0) begin a01 = c; exp_b = 32'hEF; end
                    else if (p == 0)       begin a02 = c; exp_b = 32'hDE; end
                    else if (p == 1)       begin a1 = c;  exp_b = 32'hBE; end
                    else                   begin a2 = c;  exp_b = 32'hAD; end
                    check($sformatf("rr rdata p%0d c%0d", p, c), bus.rdata, exp_b);
                end
            end
        end
        check("rr ack p0 first",  a01, 3);
        check("rr ack p1",        a1, 7);
        check("rr ack p2",        a2, 11);
        check("rr ack p0 second", a02, 15);
        check("rr ack count",     nacks, 4);
        repeat (2) @(negedge clk);

        // Reset lands after the second byte of a W4 has been committed.
        bus.op[1] = OP_W4; bus.addr[1] = 17'h00300; bus.wdata[1] = 32'h11223344;
        bus.req[1] = 1'b1;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.ack != '0) ack_seen = 1'b1;
        end
        check("abort we before rst", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort no ack",  {31'd0, ack_seen | (|bus.ack)}, 32'd0);
        check("abort mem_we",  {31'd0, mem_we}, 32'd0);
        check("abort gnt",     {29'd0, bus.gnt}, 32'd0);
        check("abort busy",    {31'd0, bus.busy}, 32'd0);
        bus.req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort mem 0x300", {24'd0, spram[17'h00300]}, 32'h44);
        check("abort mem 0x301", {24'd0, spram[17'h00301]}, 32'h33);
        check("abort mem 0x302", {24'd0, spram[17'h00302]}, 32'h00);
        check("abort mem 0x303", {24'd0, spram[17'h00303]}, 32'h00);
        run_txn('{1, OP_R4, 17'h00300, 32'h0, 32'h00003344, 1'b1, 6, 0}, "post-abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
